// File: rtl/calc_entry_fsm.sv
// calc_entry_fsm: calculator key-entry controller between the keypad driver
// and the ALU/display path. It builds decimal operands, latches the
// operator, issues ALU requests over req/ack and keeps the last result
// for the ans key.
// Optional feature macro: CALC_CHAIN_OP_EN. When defined, an operator key
// in S_B evaluates the pending expression and chains the new operator.
module calc_entry_fsm #(
    parameter int DATA_W     = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic              sw_clk,
    input  logic              rst,
    input  logic [4:0]        key_in,
    input  logic              key_stb,
    output logic              alu_req,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_ack,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_err,
    output logic [DATA_W-1:0] disp_val,
    output logic              err,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    localparam logic [3:0] K_DIV = 4'hA;
    localparam logic [3:0] K_MUL = 4'hB;
    localparam logic [3:0] K_ADD = 4'hC;
    localparam logic [3:0] K_ANS = 4'hE;
    localparam logic [3:0] K_EQ  = 4'hF;

    typedef enum logic [2:0] {S_A, S_OP, S_B, S_WAIT, S_RES, S_ERR} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, ans_q, ans_d, disp_q, disp_d;
    logic [2:0]        op_q, op_d, pend_op_q, pend_op_d;
    logic              req_q, req_d, err_q, err_d;
    logic              closed_q, closed_d, chain_q, chain_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [3:0]        key_code;
    logic              key_take, is_digit, is_op;
    logic [DATA_W-1:0] digit_val, cur_val, edit_val;
    logic [CNT_W-1:0]  edit_cnt;

    // Base operator selected by an operator key on first press.
    function automatic logic [2:0] base_op(input logic [3:0] k);
        case (k)
            K_DIV:   base_op = OP_DIV;
            K_MUL:   base_op = OP_MUL;
            default: base_op = OP_ADD;
        endcase
    endfunction

    // Repeating the same operator key flips add/sub or div/mod.
    function automatic logic [2:0] toggle_op(input logic [3:0] k, input logic [2:0] cur);
        case (k)
            K_ADD:   toggle_op = (cur == OP_ADD) ? OP_SUB : ((cur == OP_SUB) ? OP_ADD : OP_ADD);
            K_DIV:   toggle_op = (cur == OP_DIV) ? OP_MOD : ((cur == OP_MOD) ? OP_DIV : OP_DIV);
            default: toggle_op = OP_MUL;
        endcase
    endfunction

    // Key qualification and the decimal edit of whichever operand is open.
    always_comb begin
        key_code  = key_in[3:0];
        key_take  = key_stb && key_in[4] && (state_q != S_WAIT);
        is_digit  = (key_code <= 4'd9);
        is_op     = (key_code == K_DIV) || (key_code == K_MUL) || (key_code == K_ADD);
        digit_val = DATA_W'(key_code);
        cur_val   = (state_q == S_B) ? b_q : a_q;
        edit_val  = cur_val;
        edit_cnt  = cnt_q;
        if (closed_q) begin
            edit_val = digit_val;
            edit_cnt = (key_code != 4'd0) ? CNT_W'(1) : CNT_W'(0);
        end else if (cnt_q < MAX_CNT) begin
            edit_val = cur_val * DATA_W'(10) + digit_val;
            if ((cur_val != '0) || (key_code != 4'd0)) begin
                edit_cnt = cnt_q + CNT_W'(1);
            end
        end
    end

    // Next-state and datapath updates for each entry state.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        ans_d     = ans_q;
        disp_d    = disp_q;
        op_d      = op_q;
        pend_op_d = pend_op_q;
        req_d     = req_q;
        err_d     = err_q;
        closed_d  = closed_q;
        chain_d   = chain_q;
        cnt_d     = cnt_q;
        if (state_q == S_WAIT) begin
            if (req_q && alu_ack) begin
                req_d   = 1'b0;
                chain_d = 1'b0;
                if (alu_err) begin
                    err_d   = 1'b1;
                    disp_d  = '0;
                    state_d = S_ERR;
                end else if (chain_q) begin
                    a_d     = alu_res;
                    ans_d   = alu_res;
                    disp_d  = alu_res;
                    op_d    = pend_op_q;
                    state_d = S_OP;
                end else begin
                    ans_d   = alu_res;
                    disp_d  = alu_res;
                    state_d = S_RES;
                end
            end
        end else if (key_take) begin
            case (state_q)
                S_A: begin
                    if (is_digit) begin
                        a_d      = edit_val;
                        cnt_d    = edit_cnt;
                        closed_d = 1'b0;
                        disp_d   = edit_val;
                    end else if (is_op) begin
                        op_d    = base_op(key_code);
                        state_d = S_OP;
                    end else if (key_code == K_ANS) begin
                        a_d      = ans_q;
                        disp_d   = ans_q;
                        closed_d = 1'b1;
                    end
                end
                S_OP: begin
                    if (is_digit) begin
                        b_d      = digit_val;
                        disp_d   = digit_val;
                        cnt_d    = (key_code != 4'd0) ? CNT_W'(1) : CNT_W'(0);
                        closed_d = 1'b0;
                        state_d  = S_B;
                    end else if (is_op) begin
                        op_d = toggle_op(key_code, op_q);
                    end else if (key_code == K_ANS) begin
                        b_d      = ans_q;
                        disp_d   = ans_q;
                        closed_d = 1'b1;
                        state_d  = S_B;
                    end else if (key_code == K_EQ) begin
                        b_d     = a_q;
                        req_d   = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_B: begin
                    if (is_digit) begin
                        b_d      = edit_val;
                        cnt_d    = edit_cnt;
                        closed_d = 1'b0;
                        disp_d   = edit_val;
                    end else if (key_code == K_ANS) begin
                        b_d      = ans_q;
                        disp_d   = ans_q;
                        closed_d = 1'b1;
                    end else if (key_code == K_EQ) begin
                        req_d   = 1'b1;
                        state_d = S_WAIT;
                    end else if (is_op) begin
`ifdef CALC_CHAIN_OP_EN
                        pend_op_d = base_op(key_code);
                        chain_d   = 1'b1;
                        req_d     = 1'b1;
                        state_d   = S_WAIT;
`else
                        state_d = S_B;
`endif
                    end
                end
                S_RES: begin
                    if (is_digit) begin
                        a_d      = digit_val;
                        disp_d   = digit_val;
                        cnt_d    = (key_code != 4'd0) ? CNT_W'(1) : CNT_W'(0);
                        closed_d = 1'b0;
                        state_d  = S_A;
                    end else if (is_op) begin
                        a_d     = ans_q;
                        op_d    = base_op(key_code);
                        state_d = S_OP;
                    end else if (key_code == K_EQ) begin
                        a_d     = ans_q;
                        req_d   = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_ERR: begin
                    if (is_digit) begin
                        err_d    = 1'b0;
                        a_d      = digit_val;
                        disp_d   = digit_val;
                        cnt_d    = (key_code != 4'd0) ? CNT_W'(1) : CNT_W'(0);
                        closed_d = 1'b0;
                        state_d  = S_A;
                    end
                end
                default: state_d = S_A;
            endcase
        end
    end

    // State and datapath registers; reset also aborts any open handshake.
    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_A;
            a_q       <= '0;
            b_q       <= '0;
            ans_q     <= '0;
            disp_q    <= '0;
            op_q      <= OP_ADD;
            pend_op_q <= OP_ADD;
            req_q     <= 1'b0;
            err_q     <= 1'b0;
            closed_q  <= 1'b0;
            chain_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ans_q     <= ans_d;
            disp_q    <= disp_d;
            op_q      <= op_d;
            pend_op_q <= pend_op_d;
            req_q     <= req_d;
            err_q     <= err_d;
            closed_q  <= closed_d;
            chain_q   <= chain_d;
            cnt_q     <= cnt_d;
        end
    end

    assign alu_req  = req_q;
    assign alu_op   = op_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign disp_val = disp_q;
    assign err      = err_q;
    assign busy     = (state_q == S_WAIT);

endmodule
